// File: rtl/sseg_scan_driver.sv
// sseg_scan_driver: 4-digit active-low seven-segment scanner with a double-buffered frame,
// anti-ghost blanking and per-slot PWM brightness.
module sseg_scan_driver #(
    parameter int SSEG_TICK    = 16,
    parameter int BLANK_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] frame_in,
    input  logic        frame_load,
    input  logic [3:0]  brightness,
    output logic        frame_pending,
    output logic        frame_tick,
    output logic [3:0]  an,
    output logic [7:0]  seg
);
    localparam logic [SSEG_TICK-1:0] BLANK = SSEG_TICK'(BLANK_CYCLES);

    logic [SSEG_TICK-1:0] cnt_q, cnt_d;
    logic [1:0]           digit_q, digit_d;
    logic [3:0]           bright_q, bright_d;
    logic [31:0]          active_q, active_d;
    logic [31:0]          buf_q, buf_d;
    logic                 pending_q, pending_d;
    logic                 tick_q, tick_d;
    logic [3:0]           an_q, an_d;
    logic [7:0]           seg_q, seg_d;
    logic                 wrap, commit, on;

    always_comb begin
        wrap      = cnt_q == '1;
        commit    = wrap && digit_q == 2'd3 && pending_q;
        cnt_d     = cnt_q + SSEG_TICK'(1);
        digit_d   = wrap ? digit_q + 2'd1 : digit_q;
        bright_d  = wrap ? brightness : bright_q;
        active_d  = commit ? buf_q : active_q;
        buf_d     = frame_load ? frame_in : buf_q;
        // a load on the commit edge refills the buffer and keeps the frame pending
        pending_d = frame_load ? 1'b1 : (commit ? 1'b0 : pending_q);
        tick_d    = cnt_d == '0 && digit_d == 2'd0;
        on        = cnt_q >= BLANK && cnt_q[SSEG_TICK-1 -: 4] <= bright_q;
        an_d      = on ? ~(4'b0001 << digit_q) : 4'hF;
        seg_d     = on ? active_q[8*digit_q +: 8] : 8'hFF;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q     <= '0;
            digit_q   <= 2'd0;
            bright_q  <= 4'hF;
            active_q  <= 32'hFFFF_FFFF;
            buf_q     <= 32'hFFFF_FFFF;
            pending_q <= 1'b0;
            tick_q    <= 1'b0;
            an_q      <= 4'hF;
            seg_q     <= 8'hFF;
        end else begin
            cnt_q     <= cnt_d;
            digit_q   <= digit_d;
            bright_q  <= bright_d;
            active_q  <= active_d;
            buf_q     <= buf_d;
            pending_q <= pending_d;
            tick_q    <= tick_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
        end
    end

    assign frame_pending = pending_q;
    assign frame_tick    = tick_q;
    assign an            = an_q;
    assign seg           = seg_q;
endmodule

// File: tb/tb_sseg_scan_driver.sv
// tb_sseg_scan_driver: directed scan/commit/brightness/reset checks; expected digit patterns
// are queued when a frame is loaded and popped mid-slot when the display shows them.
module tb_sseg_scan_driver;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] frame_in = 32'h0;
    logic        frame_load = 1'b0;
    logic [3:0]  brightness = 4'hF;
    logic        frame_pending, frame_tick;
    logic [3:0]  an;
    logic [7:0]  seg;
    int total = 0;
    int bad = 0;

    typedef struct {
        logic [3:0] an;
        logic [7:0] seg;
    } exp_t;
    exp_t exp_q[$];

    sseg_scan_driver #(.SSEG_TICK(6), .BLANK_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .frame_in(frame_in), .frame_load(frame_load),
        .brightness(brightness), .frame_pending(frame_pending), .frame_tick(frame_tick),
        .an(an), .seg(seg)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] walk(input int s);
        return s == 0 ? 4'hE : s == 1 ? 4'hD : s == 2 ? 4'hB : 4'h7;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load(input logic [31:0] f);
        frame_in = f;
        frame_load = 1'b1;
        cyc(1);
        frame_load = 1'b0;
    endtask

    task automatic push_frame(input logic [31:0] f);
        for (int i = 0; i < 4; i++) exp_q.push_back('{an: walk(i), seg: f[8*i +: 8]});
    endtask

    task automatic wait_tick(input string tag);
        int n = 0;
        while (frame_tick !== 1'b1 && n < 600) begin
            cyc(1);
            n++;
        end
        chk(tag, {31'b0, frame_tick}, 32'd1);
    endtask

    // called at a frame_tick; checks each slot at cnt=32 and returns at cnt=32 of digit 3
    task automatic scan_frame(input string tag);
        exp_t e;
        cyc(32);
        for (int s = 0; s < 4; s++) begin
            e = exp_q.size() > 0 ? exp_q.pop_front() : '{an: 4'hx, seg: 8'hx};
            chk({tag, "_an"}, {28'b0, an}, {28'b0, e.an});
            chk({tag, "_seg"}, {24'b0, seg}, {24'b0, e.seg});
            if (s < 3) cyc(64);
        end
    endtask

    // one frame right after reset release: blank digits walking, tick only at the wrap
    task automatic blank_frame(input string tag);
        int p;
        for (int k = 1; k <= 256; k++) begin
            cyc(1);
            p = k - 1;
            chk({tag, "_an"}, {28'b0, an}, {28'b0, (p % 64) >= 4 ? walk(p / 64) : 4'hF});
            chk({tag, "_seg"}, {24'b0, seg}, 32'hFF);
            chk({tag, "_pend"}, {31'b0, frame_pending}, 32'd0);
            chk({tag, "_tick"}, {31'b0, frame_tick}, {31'b0, k == 256});
        end
    endtask

    initial begin
        logic [31:0] fb;
        int p, slot, cc, lvl;
        logic on;
        cyc(3);
        chk("rst_an", {28'b0, an}, 32'hF);
        chk("rst_seg", {24'b0, seg}, 32'hFF);
        chk("rst_pend", {31'b0, frame_pending}, 32'd0);
        chk("rst_tick", {31'b0, frame_tick}, 32'd0);
        reset = 1'b0;
        blank_frame("t1");

        cyc(74);
        load(32'hC0F9A4B0);
        push_frame(32'hC0F9A4B0);
        chk("t2_pend1", {31'b0, frame_pending}, 32'd1);
        wait_tick("t2_tick");
        chk("t2_pend0", {31'b0, frame_pending}, 32'd0);
        scan_frame("t2");

        load(32'h11111111);
        load(32'h22222222);
        push_frame(32'h22222222);
        wait_tick("t3_tick");
        scan_frame("t3");

        load(32'h33445566);
        cyc(30);
        frame_in = 32'h778899AA;
        frame_load = 1'b1;
        cyc(1);
        frame_load = 1'b0;
        chk("t4_tick", {31'b0, frame_tick}, 32'd1);
        chk("t4_pend1", {31'b0, frame_pending}, 32'd1);
        push_frame(32'h33445566);
        scan_frame("t4a");
        push_frame(32'h778899AA);
        wait_tick("t4_tick2");
        chk("t4_pend0", {31'b0, frame_pending}, 32'd0);
        scan_frame("t4b");

        fb = 32'h778899AA;
        brightness = 4'd1;
        wait_tick("t5_tick");
        for (int n = 1; n <= 192; n++) begin
            cyc(1);
            p = n - 1;
            slot = p / 64;
            cc = p % 64;
            lvl = slot < 2 ? 1 : 15;
            on = cc >= 4 && (cc / 4) <= lvl;
            chk("t5_an", {28'b0, an}, {28'b0, on ? walk(slot) : 4'hF});
            chk("t5_seg", {24'b0, seg}, {24'b0, on ? fb[8*slot +: 8] : 8'hFF});
            if (n == 84) brightness = 4'hF;
        end

        wait_tick("t6_tick");
        cyc(138);
        load(32'h12345678);
        chk("t6_pend1", {31'b0, frame_pending}, 32'd1);
        chk("t6_an_pre", {28'b0, an}, 32'hB);
        chk("t6_seg_pre", {24'b0, seg}, 32'h88);
        #2 reset = 1'b1;
        #1;
        chk("t6_an_rst", {28'b0, an}, 32'hF);
        chk("t6_seg_rst", {24'b0, seg}, 32'hFF);
        chk("t6_pend_rst", {31'b0, frame_pending}, 32'd0);
        cyc(3);
        reset = 1'b0;
        blank_frame("t6");
        chk("queue_left", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
